// File: rtl/register_file_pkg.sv
// Shared widths and architectural register indices
// for the integer register file.
package register_file_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned ZERO = 0;
  localparam int unsigned RA   = 1;
  localparam int unsigned SP   = 2;

endpackage

// File: rtl/register_file_write_decoder.sv
// One-hot write-enable decoder for the register file;
// x0 never receives an enable.
module write_decoder
  import register_file_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   enable,
  output logic [2**ADDR_W-1:0]   we
);

  localparam int unsigned NREG = 2**ADDR_W;

  always_comb begin
    we = '0;
    for (int i = 1; i < NREG; i++) begin
      we[i] = enable && (rd_addr == ADDR_W'(i));
    end
    we[ZERO] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// Integer register file: two combinational read ports,
// one synchronous write port, x0 hardwired to zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned N      = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      write_data,
  output logic [N-1:0]      read_data1,
  output logic [N-1:0]      read_data2
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [NREG-1:0] we;
  logic            wr_en;
  logic [N-1:0]    reg_q [NREG];

  // Reset outranks the write, so it also kills the bypass.
  assign wr_en = reg_write & ~rst;

  write_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .rd_addr (rd_addr),
    .enable  (wr_en),
    .we      (we)
  );

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == ZERO) begin : g_zero
      assign reg_q[g] = '0;
    end else begin : g_flop
      logic [N-1:0] reg_d;

      always_comb begin
        reg_d = reg_q[g];
        if (we[g]) reg_d = write_data;
      end

      always_ff @(posedge clk) begin
        if (rst) reg_q[g] <= '0;
        else     reg_q[g] <= reg_d;
      end
    end
  end

  function automatic logic [N-1:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [N-1:0] v;
    v = reg_q[a];
    if (BYPASS && we[a]) v = write_data;
    if (a == ADDR_W'(ZERO)) v = '0;
    return v;
  endfunction

  always_comb begin
    read_data1 = rd_port(rs1_addr);
    read_data2 = rd_port(rs2_addr);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed + random bench for register_file, running
// BYPASS=0 and BYPASS=1 instances side by side.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  register_file #(.N(32), .ADDR_W(5), .BYPASS(1'b0)) u_nb (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .read_data1 (rd1_nb),
    .read_data2 (rd2_nb)
  );

  register_file #(.N(32), .ADDR_W(5), .BYPASS(1'b1)) u_bp (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .read_data1 (rd1_bp),
    .read_data2 (rd2_bp)
  );

  // Reference: an array of 32 words, cleared by rst, x0 never written.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (reg_write && rd_addr != 5'd0) begin
      mem[rd_addr] <= write_data;
    end
  end

  function automatic logic [31:0] expect_rd(input logic [4:0] a,
                                            input bit bypass);
    if (a == 5'd0) return 32'h0;
    if (bypass && reg_write && !rst && a == rd_addr) return write_data;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " nb1"}, rd1_nb, expect_rd(rs1_addr, 1'b0));
    chk({tag, " nb2"}, rd2_nb, expect_rd(rs2_addr, 1'b0));
    chk({tag, " bp1"}, rd1_bp, expect_rd(rs1_addr, 1'b1));
    chk({tag, " bp2"}, rd2_bp, expect_rd(rs2_addr, 1'b1));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Preload x5, then reset while a write to x7 is presented
    reg_write = 1'b1; rd_addr = 5'd5; write_data = 32'hDEADBEEF;
    tick();
    reg_write = 1'b0; rs1_addr = 5'd5;
    #1;
    chk("preload x5", rd1_nb, 32'hDEADBEEF);
    rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h1234;
    tick();
    rst = 1'b0; reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a);
      #1;
      chk("reset nb1", rd1_nb, 32'h0);
      chk("reset bp2", rd2_bp, 32'h0);
    end

    // Basic write / read
    reg_write = 1'b1; rd_addr = 5'd1; write_data = 32'h0000_00FF;
    tick();
    rd_addr = 5'd31; write_data = 32'hFFFF_FFFF;
    tick();
    reg_write = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd31;
    #1;
    chk("x1", rd1_nb, 32'h0000_00FF);
    chk("x31", rd2_nb, 32'hFFFF_FFFF);
    for (int a = 2; a < 31; a++) begin
      rs1_addr = 5'(a);
      #1;
      chk("others zero", rd1_nb, 32'h0);
    end

    // x0 write ignored, also not bypassed
    reg_write = 1'b1; rd_addr = 5'd0; write_data = 32'hA5A5A5A5;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    chk("x0 no bypass", rd1_bp, 32'h0);
    tick();
    reg_write = 1'b0;
    chk("x0 after write", rd1_nb, 32'h0);
    rs1_addr = 5'd1; rs2_addr = 5'd31;
    #1;
    chk("x1 kept", rd1_nb, 32'h0000_00FF);
    chk("x31 kept", rd2_bp, 32'hFFFF_FFFF);

    // Write enable low for 4 cycles
    reg_write = 1'b0; rd_addr = 5'd3; write_data = 32'h55;
    repeat (4) tick();
    rs1_addr = 5'd3;
    #1;
    chk("we low x3", rd1_nb, 32'h0);

    // Same-cycle read/write hazard
    reg_write = 1'b1; rd_addr = 5'd4; write_data = 32'h10;
    tick();
    write_data = 32'h20; rs1_addr = 5'd4; rs2_addr = 5'd4;
    #1;
    chk("hazard nb1 old", rd1_nb, 32'h10);
    chk("hazard nb2 old", rd2_nb, 32'h10);
    chk("hazard bp1 new", rd1_bp, 32'h20);
    chk("hazard bp2 new", rd2_bp, 32'h20);
    tick();
    reg_write = 1'b0;
    chk("hazard nb after", rd1_nb, 32'h20);
    chk("hazard bp after", rd2_bp, 32'h20);

    // Bypass suppressed during reset
    rst = 1'b1; reg_write = 1'b1; write_data = 32'h77;
    #1;
    chk("rst no bypass", rd1_bp, 32'h20);
    tick();
    rst = 1'b0; reg_write = 1'b0;
    chk("rst cleared x4", rd1_bp, 32'h0);

    // Random regression against the array model
    for (int c = 0; c < 1000; c++) begin
      rst        = (c % 250 == 249);
      reg_write  = ($urandom_range(0, 3) != 0);
      rd_addr    = 5'($urandom_range(0, 31));
      rs1_addr   = ($urandom_range(0, 3) == 0) ? rd_addr
                                               : 5'($urandom_range(0, 31));
      rs2_addr   = 5'($urandom_range(0, 31));
      write_data = $urandom;
      #1;
      chk_all("rand");
      tick();
    end
    rst = 1'b0; reg_write = 1'b0; rs1_addr = 5'd0;
    #1;
    chk("x0 final", rd1_nb, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the single-cycle core, sitting between the decode stage and the ALU/writeback path.
- Provides two asynchronous read ports (rs1, rs2) and one synchronous write port (rd).
- The write side is the inverse of the operand-select muxing: the rd address drives a one-hot write decoder, and that decoder steers write_data into exactly one register.
- Register x0 is hardwired to zero, per RV32I.

Parameters:
- N, 32, data width of each register in bits.
- ADDR_W, 5, register address width; the block holds 2**ADDR_W registers.
- BYPASS, 0, when 1, a read of the register being written in the same cycle returns write_data (write-through); when 0, it returns the stored value.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable from the control unit.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rd_addr  input  ADDR_W  write address.
- write_data  input  N  data to write (writeback mux output).
- read_data1  output  N  contents of register rs1_addr.
- read_data2  output  N  contents of register rs2_addr.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
  - On a rising edge with rst=1, all 2**ADDR_W registers load 0.
  - rst has priority over reg_write, so a write presented during reset is discarded.
- Reset value of outputs: both read ports are combinational from the storage, so from the first edge with rst=1 onward, read_data1 and read_data2 are 0 for every address.
- Write:
  - On a rising edge with rst=0, reg_write=1 and rd_addr!=0, reg[rd_addr] <= write_data.
  - Exactly one register updates; all others hold.
  - Write latency is one edge.
- x0:
  - A write with rd_addr=0 is ignored.
  - A read of address 0 always returns 0, regardless of BYPASS or any pending write.
- Read:
  - Purely combinational, zero latency.
  - read_dataK = reg[rsK_addr]; no clock dependence.
- Same-cycle read/write of the same register (rsK_addr==rd_addr!=0, reg_write=1, rst=0):
  - BYPASS=0: read_dataK shows the old value until the edge and the new value after it. This is the required mode for the single-cycle core.
  - BYPASS=1: read_dataK = write_data combinationally before the edge.
  - The bypass is suppressed when rst=1.
- Both read ports may address the same register simultaneously; each returns the same value independently.
- reg_write=0: no register changes, whatever rd_addr and write_data hold.
- Reset asserted mid-program: all registers clear on that edge; the next write after rst deasserts behaves normally.
- Width rules:
  - No sign or zero extension inside the block; data passes through at N bits.
  - Addresses are used unmodified; there are no out-of-range addresses (full 2**ADDR_W decode).

Decomposition:
- Shared defines file:
  - REG_ADDR_W (5) and XLEN (32).
  - Register index constants: ZERO=0, RA=1, SP=2.
- Sub-module write_decoder:
  - Inputs: ADDR_W-bit rd_addr and enable.
  - Output: 2**ADDR_W-bit one-hot write-enable vector.
  - Bit 0 forced to 0.
  - Enable = reg_write & ~rst.
- Storage is a generate loop of N-bit registers, each gated by its decoder bit.
- Read ports index the storage array directly.

Test Plan:
- Reset: preload x5=0xDEADBEEF, then assert rst for 1 cycle with reg_write=1, rd=7, write_data=0x1234 -> after the edge, every address 0..31 reads 0, including x7.
- Basic write/read: write x1=0x0000_00FF, x31=0xFFFF_FFFF; set rs1=1, rs2=31 -> read_data1=0x0000_00FF, read_data2=0xFFFF_FFFF; all other registers stay 0.
- x0 protection: reg_write=1, rd=0, write_data=0xA5A5A5A5 -> rs1=0 reads 0 after the edge; no other register changes.
- Write enable low: reg_write=0, rd=3, write_data=0x55 for 4 cycles -> x3 remains at its prior value (0).
- Same-cycle hazard: x4=0x10 stored; reg_write=1, rd=4, write_data=0x20, rs1=rs2=4 -> with BYPASS=0, read 0x10 before the edge and 0x20 after; with BYPASS=1, read 0x20 before the edge.
- Random regression: 1000 cycles of random reg_write/rd/rs1/rs2/data with rst pulsed every 250 cycles -> read ports match a reference array model on every cycle, and x0 is always 0.
